// File: rtl/uart_xcvr_param_if.sv
// Fabric-side FIFO bus of the parametrised UART transceiver.
// The master side is the byte producer/consumer; the slave side is the UART.
interface uart_xcvr_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_wt_en;
    logic                 tx_full;
    logic                 tx_almostfull;
    logic                 rx_rd_en;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_empty;
    logic                 rx_almostempty;

    modport master (
        output tx_data, tx_wt_en, rx_rd_en,
        input  tx_full, tx_almostfull, rx_data, rx_empty, rx_almostempty
    );

    modport slave (
        input  tx_data, tx_wt_en, rx_rd_en,
        output tx_full, tx_almostfull, rx_data, rx_empty, rx_almostempty
    );
endinterface

// File: rtl/uart_xcvr_param.sv
// Parametrised UART transceiver with TX/RX FIFOs and sticky error flags.
// Define UART_LOOPBACK_EN to add the internal TX->RX loopback port.
module uart_xcvr_param #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4,
    parameter int AE_TH     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_en,
    input  logic rx_en,
    uart_xcvr_param_if.slave bus,
    output logic uart_tx,
    input  logic uart_rx,
    input  logic err_clr,
    output logic parity_err,
    output logic frame_err,
    output logic overrun_err
`ifdef UART_LOOPBACK_EN
    ,
    input  logic loopback
`endif
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int BW    = $clog2(CLK_DIV);
    localparam logic [BW-1:0] RELOAD = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] HALF   = BW'(CLK_DIV / 2);
    localparam logic [2:0]    LAST   = 3'(DATA_BITS - 1);
    localparam logic          ODD    = (PARITY == 1);
    localparam logic          HASP   = (PARITY != 0);
    localparam logic          SBLAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} st_t;

    // TX FIFO
    logic [DATA_BITS-1:0] tx_mem [DEPTH];
    logic [FIFO_AW-1:0]   tx_wp, tx_rp;
    logic [CW-1:0]        tx_cnt;
    logic                 tx_push, tx_pop, tx_empty;

    assign bus.tx_full       = tx_cnt == CW'(DEPTH);
    assign bus.tx_almostfull = tx_cnt >= CW'(DEPTH - AE_TH);
    assign tx_empty          = tx_cnt == '0;
    assign tx_push           = bus.tx_wt_en && !bus.tx_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + FIFO_AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + FIFO_AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.tx_data;
    end

    // RX FIFO
    logic [DATA_BITS-1:0] rx_mem [DEPTH];
    logic [FIFO_AW-1:0]   rx_wp, rx_rp;
    logic [CW-1:0]        rx_cnt;
    logic                 rx_full, rx_ok, rx_push, rx_pop;

    assign rx_full            = rx_cnt == CW'(DEPTH);
    assign bus.rx_empty       = rx_cnt == '0;
    assign bus.rx_almostempty = rx_cnt <= CW'(AE_TH);
    assign rx_push            = rx_ok && !rx_full;
    assign rx_pop             = bus.rx_rd_en && !bus.rx_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp       <= '0;
            rx_rp       <= '0;
            rx_cnt      <= '0;
            bus.rx_data <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + FIFO_AW'(1);
            if (rx_pop) begin
                rx_rp       <= rx_rp + FIFO_AW'(1);
                bus.rx_data <= rx_mem[rx_rp];
            end
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // TX path
    st_t                  tx_st, tx_nx;
    logic [BW-1:0]        tx_bc;
    logic [2:0]           tx_bi;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_pb, tx_sc, tx_tick, tx_line;

    assign tx_tick = tx_bc == '0;

    always_ff @(posedge clk) begin
        if (rst) tx_st <= IDLE;
        else     tx_st <= tx_nx;
    end

    always_comb begin
        tx_nx   = tx_st;
        tx_pop  = 1'b0;
        tx_line = 1'b1;
        unique case (tx_st)
            IDLE: begin
                if (tx_en && !tx_empty) begin
                    tx_pop = 1'b1;
                    tx_nx  = START;
                end
            end
            START: begin
                tx_line = 1'b0;
                if (tx_tick) tx_nx = DATA;
            end
            DATA: begin
                tx_line = tx_sh[0];
                if (tx_tick && tx_bi == LAST) tx_nx = HASP ? PAR : STOP;
            end
            PAR: begin
                tx_line = tx_pb;
                if (tx_tick) tx_nx = STOP;
            end
            STOP: if (tx_tick && tx_sc == SBLAST) tx_nx = IDLE;
            default: tx_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_bc <= RELOAD;
            tx_bi <= '0;
            tx_sh <= '0;
            tx_pb <= 1'b0;
            tx_sc <= 1'b0;
        end else begin
            if (tx_st == IDLE || tx_tick) tx_bc <= RELOAD;
            else                          tx_bc <= tx_bc - BW'(1);
            if (tx_pop) begin
                tx_sh <= tx_mem[tx_rp];
                tx_pb <= (^tx_mem[tx_rp]) ^ ODD;
                tx_bi <= '0;
                tx_sc <= 1'b0;
            end else if (tx_tick && tx_st == DATA) begin
                tx_sh <= tx_sh >> 1;
                tx_bi <= tx_bi + 3'd1;
            end else if (tx_tick && tx_st == STOP) begin
                tx_sc <= 1'b1;
            end
        end
    end

    // Loopback routing and RX synchroniser
    logic rx_src, rx_s1, rx_s2, rx_s3, rx_fall;

`ifdef UART_LOOPBACK_EN
    assign rx_src  = loopback ? tx_line : uart_rx;
    assign uart_tx = loopback | tx_line;
`else
    assign rx_src  = uart_rx;
    assign uart_tx = tx_line;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_src;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall = rx_s3 && !rx_s2;

    // RX path
    st_t                  rx_st, rx_nx;
    logic [BW-1:0]        rx_bc;
    logic [2:0]           rx_bi;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_pbad, rx_tick, pe_set, fe_set;

    assign rx_tick = rx_bc == '0;

    always_ff @(posedge clk) begin
        if (rst) rx_st <= IDLE;
        else     rx_st <= rx_nx;
    end

    always_comb begin
        rx_nx  = rx_st;
        rx_ok  = 1'b0;
        pe_set = 1'b0;
        fe_set = 1'b0;
        if (!rx_en) begin
            rx_nx = IDLE;
        end else begin
            unique case (rx_st)
                IDLE:  if (rx_fall) rx_nx = START;
                START: if (rx_tick) rx_nx = rx_s2 ? IDLE : DATA;
                DATA: begin
                    if (rx_tick && rx_bi == LAST) rx_nx = HASP ? PAR : STOP;
                end
                PAR:   if (rx_tick) rx_nx = STOP;
                STOP: begin
                    if (rx_tick) begin
                        rx_nx = IDLE;
                        if (!rx_s2)       fe_set = 1'b1;
                        else if (rx_pbad) pe_set = 1'b1;
                        else              rx_ok  = 1'b1;
                    end
                end
                default: rx_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_bc   <= HALF;
            rx_bi   <= '0;
            rx_sh   <= '0;
            rx_pbad <= 1'b0;
        end else begin
            if (rx_st == IDLE) begin
                rx_bc   <= HALF;
                rx_bi   <= '0;
                rx_pbad <= 1'b0;
            end else if (rx_tick) begin
                rx_bc <= RELOAD;
            end else begin
                rx_bc <= rx_bc - BW'(1);
            end
            if (rx_tick && rx_st == DATA) begin
                rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                rx_bi <= rx_bi + 3'd1;
            end
            if (rx_tick && rx_st == PAR) begin
                rx_pbad <= rx_s2 != ((^rx_sh) ^ ODD);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    // A new error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            parity_err  <= pe_set | (parity_err & ~err_clr);
            frame_err   <= fe_set | (frame_err & ~err_clr);
            overrun_err <= (rx_ok & rx_full) | (overrun_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_uart_xcvr_param.sv
// Randomised bench for uart_xcvr_param: serial-line model with parity,
// expected-byte queues, FIFO flag boundaries, errors and mid-frame reset.
module tb_uart_xcvr_param;
    localparam int CD    = 16;
    localparam int DB    = 8;
    localparam int PAR   = 2;
    localparam int SB    = 1;
    localparam int AW    = 4;
    localparam int TH    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int NB    = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_en = 1'b0;
    logic rx_en = 1'b0;
    logic err_clr = 1'b0;
    logic lb = 1'b0;
    logic drv = 1'b1;
    logic uart_tx, uart_rx;
    logic parity_err, frame_err, overrun_err;

    int n_tests = 0;
    int n_fail  = 0;

    uart_xcvr_param_if #(.DATA_BITS(DB)) bus ();

    assign uart_rx = lb ? uart_tx : drv;

    uart_xcvr_param #(
        .CLK_DIV(CD), .DATA_BITS(DB), .PARITY(PAR),
        .STOP_BITS(SB), .FIFO_AW(AW), .AE_TH(TH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_en(tx_en),
        .rx_en(rx_en),
        .bus(bus),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx),
        .err_clr(err_clr),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .overrun_err(overrun_err)
`ifdef UART_LOOPBACK_EN
        ,
        .loopback(1'b0)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic par_bit(input logic [DB-1:0] d);
        return (PAR == 1) ? ~(^d) : (^d);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [DB-1:0] d);
        bus.tx_data  = d;
        bus.tx_wt_en = 1'b1;
        @(negedge clk);
        bus.tx_wt_en = 1'b0;
    endtask

    task automatic pop_rx(output logic [DB-1:0] d);
        bus.rx_rd_en = 1'b1;
        @(negedge clk);
        bus.rx_rd_en = 1'b0;
        d = bus.rx_data;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic bad_par,
                              input logic bad_stop);
        drv = 1'b0;
        cyc(CD);
        for (int i = 0; i < DB; i++) begin
            drv = d[i];
            cyc(CD);
        end
        if (PAR != 0) begin
            drv = par_bit(d) ^ bad_par;
            cyc(CD);
        end
        drv = !bad_stop;
        cyc(CD * SB);
        drv = 1'b1;
        cyc(bad_stop ? CD : 4);
    endtask

    task automatic mon_tx(output logic [DB-1:0] d, output logic p,
                          output logic s);
        int t;
        t = 0;
        d = '0;
        p = 1'b0;
        while (uart_tx !== 1'b0 && t < NB * CD * 2) begin
            @(negedge clk);
            t++;
        end
        check("tx_start_seen", uart_tx, 1'b0);
        cyc(CD / 2);
        check("tx_start_bit", uart_tx, 1'b0);
        for (int i = 0; i < DB; i++) begin
            cyc(CD);
            d[i] = uart_tx;
        end
        if (PAR != 0) begin
            cyc(CD);
            p = uart_tx;
        end
        cyc(CD);
        s = uart_tx;
    endtask

    task automatic count_low(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
    endtask

    logic [DB-1:0] d, got, prev;
    logic          p, s;
    int            t, lows;
    logic [DB-1:0] q[$];

    initial begin
        bus.tx_data  = '0;
        bus.tx_wt_en = 1'b0;
        bus.rx_rd_en = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_tx_full", bus.tx_full, 1'b0);
        check("rst_tx_afull", bus.tx_almostfull, 1'b0);
        check("rst_rx_empty", bus.rx_empty, 1'b1);
        check("rst_rx_aempty", bus.rx_almostempty, 1'b1);
        check("rst_rx_data", bus.rx_data, '0);
        check("rst_errs", {parity_err, frame_err, overrun_err}, 3'b000);

        // external loopback of random bytes
        rx_en = 1'b1;
        lb    = 1'b1;
        tx_en = 1'b1;
        d = 8'h41;
        for (int k = 0; k < 5; k++) begin
            push_tx(d);
            t = 0;
            while (bus.rx_empty && t < NB * CD + 50) begin
                @(negedge clk);
                t++;
            end
            check("lb_rx_ready", bus.rx_empty, 1'b0);
            pop_rx(got);
            check("lb_data", got, d);
            cyc(3);
            check("lb_data_hold", bus.rx_data, d);
            check("lb_errs", {parity_err, frame_err, overrun_err}, 3'b000);
            d = DB'($urandom);
        end
        cyc(NB * CD);
        tx_en = 1'b0;
        lb    = 1'b0;
        cyc(4);

        // TX FIFO fill past full with TX disabled
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_tx(DB'(i));
            if (i == DEPTH - TH - 2) check("tx_afull_below", bus.tx_almostfull, 1'b0);
            if (i == DEPTH - TH - 1) check("tx_afull_at", bus.tx_almostfull, 1'b1);
            if (i == DEPTH - 2) check("tx_full_below", bus.tx_full, 1'b0);
            if (i >= DEPTH - 1) check("tx_full", bus.tx_full, 1'b1);
        end
        tx_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            mon_tx(got, p, s);
            check("tx_data", got, DB'(i));
            check("tx_parity", p, par_bit(DB'(i)));
            check("tx_stop", s, 1'b1);
        end
        count_low(NB * CD * 2, lows);
        check("tx_no_extra", lows, 0);
        check("tx_afull_drained", bus.tx_almostfull, 1'b0);
        tx_en = 1'b0;

        // bad parity, then clear
        send_frame(8'h55, 1'b1, 1'b0);
        check("par_err_set", parity_err, 1'b1);
        check("par_rx_empty", bus.rx_empty, 1'b1);
        check("par_no_frame", frame_err, 1'b0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("par_err_clr", parity_err, 1'b0);

        // bad stop bit
        send_frame(8'hA5, 1'b0, 1'b1);
        check("frm_err_set", frame_err, 1'b1);
        check("frm_rx_empty", bus.rx_empty, 1'b1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("frm_err_clr", frame_err, 1'b0);

        // quarter-bit glitch
        drv = 1'b0;
        cyc(CD / 4);
        drv = 1'b1;
        cyc(CD * 3);
        check("glitch_rx_empty", bus.rx_empty, 1'b1);
        check("glitch_errs", {parity_err, frame_err, overrun_err}, 3'b000);

        // overrun: one frame more than the RX FIFO holds
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = DB'($urandom);
            send_frame(d, 1'b0, 1'b0);
            if (q.size() < DEPTH) q.push_back(d);
            if (i == DEPTH - 1) check("ovr_before", overrun_err, 1'b0);
        end
        check("ovr_set", overrun_err, 1'b1);
        check("ovr_aempty", bus.rx_almostempty, 1'b0);
        check("ovr_other_errs", {parity_err, frame_err}, 2'b00);
        for (int i = 0; i < DEPTH; i++) begin
            pop_rx(got);
            prev = q.pop_front();
            check("ovr_data", got, prev);
            if (i == DEPTH - TH - 2) check("rx_aempty_above", bus.rx_almostempty, 1'b0);
            if (i == DEPTH - TH - 1) check("rx_aempty_at", bus.rx_almostempty, 1'b1);
        end
        check("ovr_drained", bus.rx_empty, 1'b1);
        pop_rx(got);
        check("empty_read_hold", got, prev);

        // reset in the middle of a TX frame
        send_frame(DB'($urandom), 1'b0, 1'b0);
        check("pre_rst_rx", bus.rx_empty, 1'b0);
        push_tx(8'hC3);
        push_tx(8'h3C);
        tx_en = 1'b1;
        t = 0;
        while (uart_tx !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("pre_rst_start", uart_tx, 1'b0);
        cyc(CD * 5 + CD / 2);
        rst = 1'b1;
        cyc(1);
        check("mrst_uart_tx", uart_tx, 1'b1);
        check("mrst_rx_empty", bus.rx_empty, 1'b1);
        check("mrst_rx_data", bus.rx_data, '0);
        check("mrst_tx_afull", bus.tx_almostfull, 1'b0);
        check("mrst_errs", {parity_err, frame_err, overrun_err}, 3'b000);
        rst = 1'b0;
        count_low(NB * CD * 2, lows);
        check("mrst_tx_idle", lows, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_xcvr_param.md
Name: uart_xcvr_param

Overview:
- Parametrised single-clock UART transceiver with TX and RX FIFOs; next-generation replacement for the fixed 8N1 UART_module.
- Adds configurable data width, parity, stop bits, FIFO depth, an almost-full/almost-empty threshold, and sticky error flags for parity, framing and overrun.
- Sits between a fabric-side byte producer/consumer and the board UART pins. Both fabric FIFO ports run on the single core clock.

Parameters:
- CLK_DIV, 434, core clocks per bit period; must be >= 4.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW, applies to each FIFO.
- AE_TH, 2, RX almost-empty threshold and TX almost-full threshold, in entries.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- tx_en  in  1  enables TX frame launch.
- rx_en  in  1  enables RX frame detection.
- tx_data  in  DATA_BITS  write data for the TX FIFO.
- tx_wt_en  in  1  TX FIFO write strobe.
- tx_full  out  1  TX FIFO full.
- tx_almostfull  out  1  TX FIFO count >= depth-AE_TH.
- uart_tx  out  1  serial output; idles high.
- uart_rx  in  1  serial input; asynchronous to clk.
- rx_rd_en  in  1  RX FIFO read strobe.
- rx_data  out  DATA_BITS  RX FIFO read data.
- rx_empty  out  1  RX FIFO empty.
- rx_almostempty  out  1  RX FIFO count <= AE_TH.
- err_clr  in  1  clears all sticky error flags.
- parity_err  out  1  sticky parity error.
- frame_err  out  1  sticky framing error.
- overrun_err  out  1  sticky RX overrun.

Behaviour:
- Reset (rst high at a clk edge):
  - FIFO pointers and counts cleared; both FSMs go to IDLE.
  - Outputs: uart_tx=1, tx_full=0, tx_almostfull=0, rx_empty=1, rx_almostempty=1, rx_data=0, all error flags=0.
  - rst asserted mid-frame aborts the frame immediately; uart_tx=1 on the following cycle.
- FIFOs:
  - Write is accepted only when wt_en=1 and full=0. A write while full is dropped silently, even if a read occurs in the same cycle.
  - Read is accepted only when rd_en=1 and empty=0. rx_data is registered and updates 1 cycle after an accepted read. rx_data holds its value otherwise.
  - Simultaneous accepted read and write leaves the count unchanged.
  - Flags derive from the registered count and update in the cycle after the pointer change.
  - Pointers wrap modulo depth.
- Baud generation:
  - Separate down-counters for TX and RX, each reloaded with CLK_DIV-1.
  - A bit tick occurs when the counter reaches 0.
- TX FSM, states IDLE, START, DATA, PARITY, STOP:
  - IDLE: when tx_en=1 and the TX FIFO is non-empty, pop one entry and go to START on the next cycle.
  - Each state drives uart_tx for exactly CLK_DIV cycles.
  - START drives 0.
  - DATA sends DATA_BITS bits, LSB first.
  - PARITY is entered only if PARITY!=0. The parity bit is XOR of the data bits, inverted for odd parity.
  - STOP drives 1 for STOP_BITS*CLK_DIV cycles, then returns to IDLE.
  - Back-to-back frames have no extra idle gap beyond 1 clock.
  - Deasserting tx_en mid-frame lets the current frame complete; no new pop follows.
- RX FSM, states IDLE, START, DATA, PARITY, STOP:
  - uart_rx passes through a 2-flop synchroniser (2-cycle input latency).
  - IDLE: when rx_en=1 and a 1->0 edge is seen on the synchronised line, go to START and load the counter with CLK_DIV/2.
  - START: at mid-bit, if the line is still 0, go to DATA; otherwise treat it as a glitch and return to IDLE with nothing stored.
  - DATA: sample each bit at mid-bit, shifting LSB first.
  - PARITY: sample and check the parity bit.
  - STOP: sample only the first stop bit.
  - If the stop bit is 0: set frame_err, discard the byte, return to IDLE.
  - If the parity check fails: set parity_err, discard the byte.
  - Otherwise push the byte. If the RX FIFO is full, set overrun_err and drop the byte; existing contents are kept.
  - rx_en deasserted mid-frame returns the FSM to IDLE on the next cycle and discards the partial byte.
- Error flags:
  - err_clr clears all three flags in the next cycle.
  - A new error in the same cycle as err_clr wins; the flag remains 1.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV clocks.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- When defined: adds input port `loopback` (1 bit). When loopback=1, the RX synchroniser input is taken from the internal TX serial signal and uart_tx is held at 1.
- When undefined: the port is absent and RX always samples uart_rx.

Test Plan:
- CLK_DIV=16, 8N1, loopback: write 0x41 -> after 160+ clocks rx_empty=0; read returns 0x41 1 cycle after rx_rd_en; no error flags set.
- Write 17 bytes 0x00..0x10 with tx_en=0 and FIFO_AW=4 -> tx_full=1 after 16 writes; 0x10 dropped; enabling TX transmits 0x00..0x0F only.
- PARITY=2: inject frame 0x55 with parity bit 1 (wrong) -> parity_err=1, rx_empty stays 1; assert err_clr -> parity_err=0 next cycle.
- Inject 0xA5 with stop bit 0 -> frame_err=1, byte not stored. Inject a 0.25-bit low glitch -> no state change, nothing stored.
- Receive 17 frames with no reads, depth 16 -> overrun_err=1; first 16 bytes read back intact in order.
- Assert rst at bit 4 of a TX frame -> uart_tx=1 the next cycle; FIFOs empty; all flags 0.
